atmega_eep_sync: RTL and testbench

Bulk-transfer engine on the external port of the ATMEGA EEPROM peripheral. Streams a full EEPROM image in from an upstream byte source (boot loader, UART or SPI-flash reader) or out to a downstream byte sink (save-to-flash path). Drives the EEPROM's external address, data, read, write and enable lines, and holds the CPU-side EEPROM off the array for the duration of a transfer.

---
 rtl/atmega_eep_pkg.sv | 17 +
 rtl/atmega_eep_sync.sv | 154 +++++++++++++++
 tb/tb_atmega_eep_sync.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/atmega_eep_pkg.sv
// Shared constants and state encoding for the EEPROM external-port transfer engine.
package atmega_eep_pkg;

    localparam int unsigned EEP_ADDR_LEN = 17;
    localparam int unsigned EEP_DATA_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_L_ACC = 3'd1,
        ST_L_WR  = 3'd2,
        ST_D_SET = 3'd3,
        ST_D_CAP = 3'd4,
        ST_D_OUT = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

endpackage

// File: rtl/atmega_eep_sync.sv
// Bulk load/dump engine on the EEPROM external port: streams a whole image
// in from a byte source or out to a byte sink, one address at a time.
module atmega_eep_sync
    import atmega_eep_pkg::state_e,
           atmega_eep_pkg::ST_IDLE,
           atmega_eep_pkg::ST_L_ACC,
           atmega_eep_pkg::ST_L_WR,
           atmega_eep_pkg::ST_D_SET,
           atmega_eep_pkg::ST_D_CAP,
           atmega_eep_pkg::ST_D_OUT,
           atmega_eep_pkg::ST_FIN,
           atmega_eep_pkg::EEP_DATA_W;
#(
    parameter int unsigned EEP_SIZE     = 512,
    parameter int unsigned EEP_ADDR_LEN = atmega_eep_pkg::EEP_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    dump_start,
    input  logic                    abort,
    input  logic [EEP_DATA_W-1:0]   load_data,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [EEP_DATA_W-1:0]   dump_data,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic [EEP_ADDR_LEN-1:0] eep_addr,
    output logic [EEP_DATA_W-1:0]   eep_wdata,
    output logic                    eep_wr,
    output logic                    eep_rd,
    output logic                    eep_en,
    input  logic [EEP_DATA_W-1:0]   eep_rdata,
    output logic                    busy,
    output logic                    done
);

    localparam logic [EEP_ADDR_LEN-1:0] ADDR_LAST = EEP_ADDR_LEN'(EEP_SIZE - 1);
    localparam logic [EEP_ADDR_LEN-1:0] ADDR_ONE  = EEP_ADDR_LEN'(1);

    state_e                  state_q, state_d;
    logic [EEP_ADDR_LEN-1:0] addr_q, addr_d;
    logic [EEP_DATA_W-1:0]   wdata_q, wdata_d;
    logic [EEP_DATA_W-1:0]   ddata_q, ddata_d;
    logic                    load_ready_q, load_ready_d;
    logic                    dump_valid_q, dump_valid_d;
    logic                    eep_wr_q, eep_wr_d;
    logic                    eep_rd_q, eep_rd_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Next state, address counter, data latches and next-cycle output values.
    // Handshakes are taken from the registered ready/valid (implied by the
    // state), so load_valid/dump_ready only ever steer registers.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ddata_d = ddata_q;

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_d = ST_L_ACC;
                        addr_d  = '0;
                    end else if (dump_start) begin
                        state_d = ST_D_SET;
                        addr_d  = '0;
                    end
                end
                ST_L_ACC: begin
                    if (load_valid) begin
                        wdata_d = load_data;
                        state_d = ST_L_WR;
                    end
                end
                ST_L_WR: begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = ST_L_ACC;
                    end
                end
                ST_D_SET: state_d = ST_D_CAP;
                ST_D_CAP: begin
                    ddata_d = eep_rdata;
                    state_d = ST_D_OUT;
                end
                ST_D_OUT: begin
                    if (dump_ready) begin
                        if (addr_q == ADDR_LAST) begin
                            state_d = ST_FIN;
                        end else begin
                            addr_d  = addr_q + ADDR_ONE;
                            state_d = ST_D_SET;
                        end
                    end
                end
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        load_ready_d = (state_d == ST_L_ACC);
        eep_wr_d     = (state_d == ST_L_WR);
        eep_rd_d     = (state_d == ST_D_SET) || (state_d == ST_D_CAP);
        dump_valid_d = (state_d == ST_D_OUT);
        done_d       = (state_d == ST_FIN);
        busy_d       = (state_d != ST_IDLE);
    end

    // State, counter and output registers; reset returns everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            ddata_q      <= '0;
            load_ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            eep_wr_q     <= 1'b0;
            eep_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ddata_q      <= ddata_d;
            load_ready_q <= load_ready_d;
            dump_valid_q <= dump_valid_d;
            eep_wr_q     <= eep_wr_d;
            eep_rd_q     <= eep_rd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = ddata_q;
    assign eep_addr   = addr_q;
    assign eep_wdata  = wdata_q;
    assign eep_wr     = eep_wr_q;
    assign eep_rd     = eep_rd_q;
    assign eep_en     = busy_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_atmega_eep_sync.sv
// Directed bench for atmega_eep_sync with an 8-byte image and a small
// synchronous EEPROM array model sharing the engine's reset.
module tb_atmega_eep_sync;

    localparam int unsigned SZ = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        dump_start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [7:0]  dump_data;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [16:0] eep_addr;
    logic [7:0]  eep_wdata;
    logic        eep_wr;
    logic        eep_rd;
    logic        eep_en;
    logic [7:0]  eep_rdata;
    logic        busy;
    logic        done;

    int vecs = 0;
    int errs = 0;

    logic [7:0] mem [SZ];
    logic [7:0] e1 [SZ];
    logic [7:0] e2 [SZ];

    atmega_eep_sync #(.EEP_SIZE(SZ), .EEP_ADDR_LEN(17)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .dump_start(dump_start), .abort(abort),
        .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
        .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .eep_addr(eep_addr), .eep_wdata(eep_wdata), .eep_wr(eep_wr),
        .eep_rd(eep_rd), .eep_en(eep_en), .eep_rdata(eep_rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // EEPROM array: registered read, write ignored while the shared reset is high.
    always @(posedge clk) begin
        if (eep_wr && eep_en && !rst) mem[eep_addr[2:0]] <= eep_wdata;
        if (eep_rd) eep_rdata <= mem[eep_addr[2:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd0);
        chk({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
        chk({tag, "_dump_data"},  32'(dump_data),  32'd0);
        chk({tag, "_eep_addr"},   32'(eep_addr),   32'd0);
        chk({tag, "_eep_wdata"},  32'(eep_wdata),  32'd0);
        chk({tag, "_eep_wr"},     32'(eep_wr),     32'd0);
        chk({tag, "_eep_rd"},     32'(eep_rd),     32'd0);
        chk({tag, "_eep_en"},     32'(eep_en),     32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
    endtask

    // Load base+i into address i; optional simultaneous dump_start, a stray
    // dump_start mid-image, a 10-cycle upstream stall, or reset in L_WR at rst_at.
    task automatic run_load(input logic [7:0] base, input bit both, input bit poke,
                            input bit stall_en, input int rst_at);
        int acc = 0;
        int wr = 0;
        int dn = 0;
        int stall = 0;
        bit stalled = 1'b0;
        bit fin = 1'b0;
        @(negedge clk);
        load_start = 1'b1; dump_start = both; load_valid = 1'b1; load_data = base;
        @(negedge clk);
        load_start = 1'b0; dump_start = 1'b0;
        chk("ld_busy_rise",   32'(busy),       32'd1);
        chk("ld_ready_entry", 32'(load_ready), 32'd1);
        chk("ld_no_dump_rd",  32'(eep_rd),     32'd0);
        for (int k = 0; k < 300 && !fin; k++) begin
            if (k != 0) @(negedge clk);
            dump_start = 1'b0;
            if (dn != 0) begin
                chk("ld_busy_fall", 32'(busy), 32'd0);
                chk("ld_done_pulse", 32'(done), 32'd0);
                fin = 1'b1;
            end else begin
                if (stall != 0) begin
                    chk("ld_stall_nowr",  32'(eep_wr),     32'd0);
                    chk("ld_stall_busy",  32'(busy),       32'd1);
                    chk("ld_stall_ready", 32'(load_ready), 32'd1);
                    stall--;
                end
                if (eep_wr) begin
                    chk("ld_addr",  32'(eep_addr),  32'(wr));
                    chk("ld_wdata", 32'(eep_wdata), 32'(base + 8'(wr)));
                    if (wr == rst_at) begin
                        rst = 1'b1;
                        @(negedge clk);
                        chk_zero("ld_rst_mid");
                        rst = 1'b0;
                        load_valid = 1'b0;
                        return;
                    end
                    wr++;
                end
                if (done) begin
                    dn++;
                    chk("ld_wr_count", 32'(wr), 32'(SZ));
                end
                if (stall == 0) load_valid = 1'b1;
                if (load_ready && load_valid) begin
                    if (stall_en && acc == 4 && !stalled) begin
                        stalled = 1'b1; stall = 10; load_valid = 1'b0;
                    end else begin
                        load_data = base + 8'(acc);
                        acc++;
                        if (poke && acc == 3) dump_start = 1'b1;
                    end
                end
            end
        end
        load_valid = 1'b0;
        chk("ld_finished",  32'(fin), 32'd1);
        chk("ld_done_once", 32'(dn),  32'd1);
    endtask

    // Dump the image and compare with exp; optional 1-0-1 sink backpressure and
    // abort while byte abort_at is being offered.
    task automatic run_dump(input logic [7:0] exp [SZ], input bit toggle, input int abort_at);
        int got = 0;
        int dn = 0;
        int k0 = -1;
        bit held = 1'b0;
        bit fin = 1'b0;
        logic [7:0] hv = '0;
        @(negedge clk);
        dump_start = 1'b1; dump_ready = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        chk("dp_busy_rise", 32'(busy),       32'd1);
        chk("dp_rd_set",    32'(eep_rd),     32'd1);
        chk("dp_no_ready",  32'(load_ready), 32'd0);
        for (int k = 0; k < 300 && !fin; k++) begin
            if (k != 0) @(negedge clk);
            if (dn != 0) begin
                chk("dp_busy_fall", 32'(busy), 32'd0);
                fin = 1'b1;
            end else begin
                if (eep_rd) chk("dp_addr", 32'(eep_addr), 32'(got));
                if (dump_valid && k0 < 0) begin
                    k0 = k;
                    chk("dp_latency", 32'(k), 32'd2);
                end
                if (held) begin
                    chk("dp_hold_data",  32'(dump_data),  32'(hv));
                    chk("dp_hold_valid", 32'(dump_valid), 32'd1);
                    held = 1'b0;
                end
                if (done) begin
                    dn++;
                    chk("dp_count", 32'(got), 32'(SZ));
                end
                if (abort_at == got && dump_valid) begin
                    abort = 1'b1; dump_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0; dump_ready = 1'b0;
                    chk("ab_valid", 32'(dump_valid), 32'd0);
                    chk("ab_busy",  32'(busy),       32'd0);
                    chk("ab_done",  32'(done),       32'd0);
                    chk("ab_en",    32'(eep_en),     32'd0);
                    chk("ab_rd",    32'(eep_rd),     32'd0);
                    @(negedge clk);
                    chk("ab_no_done_late", 32'(done), 32'd0);
                    return;
                end
                dump_ready = toggle ? ~dump_ready : 1'b1;
                if (dump_valid) begin
                    if (dump_ready) begin
                        chk("dp_data", 32'(dump_data), 32'(exp[got]));
                        got++;
                    end else begin
                        held = 1'b1;
                        hv = dump_data;
                    end
                end
            end
        end
        dump_ready = 1'b0;
        chk("dp_finished",  32'(fin), 32'd1);
        chk("dp_done_once", 32'(dn),  32'd1);
    endtask

    initial begin
        for (int i = 0; i < int'(SZ); i++) begin
            e1[i] = 8'h10 + 8'(i);
            e2[i] = (i < 5) ? 8'h40 + 8'(i) : 8'h10 + 8'(i);
        end
        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;

        run_load(8'h10, 1'b1, 1'b1, 1'b1, -1);
        run_dump(e1, 1'b0, -1);
        run_dump(e1, 1'b1, -1);
        run_dump(e1, 1'b1, 3);
        run_dump(e1, 1'b0, -1);
        run_load(8'h40, 1'b0, 1'b0, 1'b0, 5);
        run_dump(e2, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
